// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute stage.
//   XLEN       datapath width (only 32 is supported)
//   alu_op_t   4-bit operation codes, including the reserved ones
//   ex_state_t iterative-unit states (idle, shifting, multiplying)
// The multiplier is built only when EX_MUL_EN is defined.
package ex_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MulIters = 32;
    // Wide enough to hold MulIters.
    localparam int unsigned CntW     = 6;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpSlt   = 4'd5,
        OpSltu  = 4'd6,
        OpSll   = 4'd7,
        OpSrl   = 4'd8,
        OpSra   = 4'd9,
        OpMul   = 4'd10,
        OpRes11 = 4'd11,
        OpRes12 = 4'd12,
        OpRes13 = 4'd13,
        OpRes14 = 4'd14,
        OpRes15 = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StMul   = 2'd2
    } ex_state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        return (op == OpSll) || (op == OpSrl) || (op == OpSra);
    endfunction

endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX input bundle and EX/MEM output bundle of the execute stage.
//   master: the surrounding pipeline (drives operands/controls and out_ready)
//   slave : ex_stage (drives in_ready, the registered result bundle and busy)
interface ex_if;
    import ex_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] data_in_1;
    logic [XLEN-1:0] data_in_2;
    logic [XLEN-1:0] imm_in;
    logic [4:0]      rd_in;
    logic [3:0]      alu_op_in;
    logic            alusrc_in;
    logic            pcsrc_in;
    logic            memtoreg_in;
    logic            we_in;
    logic            reg_en_in;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_out;
    logic [XLEN-1:0] store_data_out;
    logic [4:0]      rd_out;
    logic            memtoreg_out;
    logic            we_out;
    logic            reg_en_out;
    logic            branch_taken_out;
    logic            busy;

    modport master (
        output in_valid, data_in_1, data_in_2, imm_in, rd_in, alu_op_in, alusrc_in,
               pcsrc_in, memtoreg_in, we_in, reg_en_in, out_ready,
        input  in_ready, out_valid, result_out, store_data_out, rd_out, memtoreg_out,
               we_out, reg_en_out, branch_taken_out, busy
    );

    modport slave (
        input  in_valid, data_in_1, data_in_2, imm_in, rd_in, alu_op_in, alusrc_in,
               pcsrc_in, memtoreg_in, we_in, reg_en_in, out_ready,
        output in_ready, out_valid, result_out, store_data_out, rd_out, memtoreg_out,
               we_out, reg_en_out, branch_taken_out, busy
    );

endinterface

// File: rtl/ex_iter_unit.sv
// ex_iter_unit: iterative shifter (1 bit/cycle) and, when EX_MUL_EN is defined,
// a 32-iteration radix-2 shift-add multiplier.
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   start         load operands and begin (only for iterative operations)
//   abort         squash the running operation and return to idle
//   op, a, b      operation, operand A, operand B (shift amount is b[4:0])
//   done          result valid this cycle (combinational, last iteration)
//   busy          an operation is in progress
//   result        final value, meaningful while done is high
module ex_iter_unit
    import ex_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic            busy,
    output logic [XLEN-1:0] result
);

    ex_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] acc_q, acc_step;
    logic            shift_left_q, shift_arith_q;
    logic            last_iter;

`ifdef EX_MUL_EN
    logic [XLEN-1:0] mcand_q, mplier_q;
`else
    logic unused_b;
    assign unused_b = ^b[XLEN-1:5];
`endif

    assign last_iter = (cnt_q == CntW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
`ifdef EX_MUL_EN
                    state_d = (op == OpMul) ? StMul : StShift;
`else
                    state_d = StShift;
`endif
                end
            end
            StShift, StMul: begin
                if (abort || last_iter) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done   = busy && last_iter && !abort;
        // The output register captures the value the final iteration produces.
        result = acc_step;
    end

    always_comb begin
        acc_step = acc_q;
        case (state_q)
            StShift: begin
                acc_step = shift_left_q ? {acc_q[XLEN-2:0], 1'b0}
                                        : {shift_arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]};
            end
`ifdef EX_MUL_EN
            StMul: acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
            default: acc_step = acc_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            shift_left_q  <= 1'b0;
            shift_arith_q <= 1'b0;
`ifdef EX_MUL_EN
            mcand_q       <= '0;
            mplier_q      <= '0;
`endif
        end else if (abort) begin
            cnt_q <= '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                shift_left_q  <= (op == OpSll);
                shift_arith_q <= (op == OpSra);
`ifdef EX_MUL_EN
                mcand_q       <= a;
                mplier_q      <= b;
                if (op == OpMul) begin
                    cnt_q <= CntW'(MulIters);
                    acc_q <= '0;
                end else begin
                    cnt_q <= CntW'(b[4:0]);
                    acc_q <= a;
                end
`else
                cnt_q <= CntW'(b[4:0]);
                acc_q <= a;
`endif
            end
        end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CntW'(1);
`ifdef EX_MUL_EN
            mcand_q  <= {mcand_q[XLEN-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
`endif
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the in-order RISC-V pipeline.
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   flush         synchronous squash of the in-flight and held instruction
//   bus (slave)   ID/EX bundle in with valid/ready, EX/MEM bundle out with
//                 valid/ready, plus busy while a shift or multiply iterates
// Single-cycle ALU ops complete at the accept edge; non-zero shifts take shamt
// cycles and MUL takes 32 cycles (MUL only when EX_MUL_EN is defined; otherwise
// opcode 10 is reserved and yields 0).
module ex_stage
    import ex_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic flush,
    ex_if.slave  bus
);

    alu_op_t         op;
    logic [XLEN-1:0] opa, opb, alu_res, iter_result;
    logic [4:0]      shamt;
    logic            is_iter, in_ready, accept, iter_start, iter_done, iter_busy;

    logic            out_valid_q;
    logic [XLEN-1:0] result_q, store_data_q;
    logic [4:0]      rd_q;
    logic            memtoreg_q, we_q, reg_en_q, branch_taken_q;

    assign op    = alu_op_t'(bus.alu_op_in);
    assign opa   = bus.data_in_1;
    assign opb   = bus.alusrc_in ? bus.imm_in : bus.data_in_2;
    assign shamt = opb[4:0];

    always_comb begin
        is_iter = is_shift_op(op) && (shamt != 5'd0);
`ifdef EX_MUL_EN
        if (op == OpMul) is_iter = 1'b1;
`endif
    end

    assign in_ready   = !iter_busy && (!out_valid_q || bus.out_ready) && !flush;
    assign accept     = bus.in_valid && in_ready;
    assign iter_start = accept && is_iter;

    always_comb begin
        alu_res = '0;
        case (op)
            OpAdd:  alu_res = opa + opb;
            OpSub:  alu_res = opa - opb;
            OpAnd:  alu_res = opa & opb;
            OpOr:   alu_res = opa | opb;
            OpXor:  alu_res = opa ^ opb;
            OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            OpSltu: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
            // Reaches this path only with shamt == 0.
            OpSll, OpSrl, OpSra: alu_res = opa;
            default: alu_res = '0;
        endcase
    end

    ex_iter_unit u_iter (
        .clock  (clock),
        .reset  (reset),
        .start  (iter_start),
        .abort  (flush),
        .op     (op),
        .a      (opa),
        .b      (opb),
        .done   (iter_done),
        .busy   (iter_busy),
        .result (iter_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            result_q       <= '0;
            store_data_q   <= '0;
            rd_q           <= '0;
            memtoreg_q     <= 1'b0;
            we_q           <= 1'b0;
            reg_en_q       <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept && !is_iter) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
            end else if (iter_done) begin
                out_valid_q <= 1'b1;
                result_q    <= iter_result;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Side-band is captured at accept; accept only happens when the
            // output register is empty or being drained this cycle.
            if (accept) begin
                store_data_q   <= bus.data_in_2;
                rd_q           <= bus.rd_in;
                memtoreg_q     <= bus.memtoreg_in;
                we_q           <= bus.we_in;
                reg_en_q       <= bus.reg_en_in;
                branch_taken_q <= bus.pcsrc_in && (bus.data_in_1 == bus.data_in_2);
            end
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid_q;
    assign bus.result_out       = result_q;
    assign bus.store_data_out   = store_data_q;
    assign bus.rd_out           = rd_q;
    assign bus.memtoreg_out     = memtoreg_q;
    assign bus.we_out           = we_q;
    assign bus.reg_en_out       = reg_en_q;
    assign bus.branch_taken_out = branch_taken_q;
    assign bus.busy             = iter_busy;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage with directed scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_ex_stage;

    logic clock;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    ex_if bus();

    ex_stage dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input int op, input logic [31:0] a,
                                                 input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return (a < b) ? 32'd1 : 32'd0;
            7: return a << b[4:0];
            8: return a >> b[4:0];
            9: return 32'($signed(a) >>> b[4:0]);
`ifdef EX_MUL_EN
            10: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input int op, input logic [31:0] b);
        if (op >= 7 && op <= 9) return int'(b[4:0]);
`ifdef EX_MUL_EN
        if (op == 10) return 32;
`endif
        return 0;
    endfunction

    task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b2,
                         input logic [31:0] imm, input logic alusrc, input logic [4:0] rd,
                         input logic [2:0] ctrl, input logic pcsrc);
        bus.alu_op_in  = 4'(op);
        bus.data_in_1  = a;
        bus.data_in_2  = b2;
        bus.imm_in     = imm;
        bus.alusrc_in  = alusrc;
        bus.rd_in      = rd;
        {bus.memtoreg_in, bus.we_in, bus.reg_en_in} = ctrl;
        bus.pcsrc_in   = pcsrc;
        bus.in_valid   = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "/result"}, bus.result_out, 32'd0);
        check({tag, "/store"}, bus.store_data_out, 32'd0);
        check({tag, "/rd"}, 32'(bus.rd_out), 32'd0);
        check({tag, "/memtoreg"}, 32'(bus.memtoreg_out), 32'd0);
        check({tag, "/we"}, 32'(bus.we_out), 32'd0);
        check({tag, "/reg_en"}, 32'(bus.reg_en_out), 32'd0);
        check({tag, "/branch"}, 32'(bus.branch_taken_out), 32'd0);
        check({tag, "/busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Entered between edges with the stage idle and out_ready high.
    task automatic run_op(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b2, input logic [31:0] imm, input logic alusrc,
                          input logic [4:0] rd, input logic [2:0] ctrl, input logic pcsrc);
        logic [31:0] opb;
        int          lat;
        int          k;
        logic        bad;
        opb = alusrc ? imm : b2;
        lat = model_latency(op, opb);
        drive(op, a, b2, imm, alusrc, rd, ctrl, pcsrc);
        #1;
        check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        k   = 0;
        bad = 1'b0;
        while (!bus.out_valid && k < 40) begin
            if (!bus.busy || bus.in_ready) bad = 1'b1;
            @(posedge clock);
            #1;
            k++;
        end
        check({tag, "/latency"}, 32'(k), 32'(lat));
        check({tag, "/busy_wait"}, 32'(bad), 32'd0);
        check({tag, "/result"}, bus.result_out, model_result(op, a, opb));
        check({tag, "/rd"}, 32'(bus.rd_out), 32'(rd));
        check({tag, "/store"}, bus.store_data_out, b2);
        check({tag, "/ctrl"}, 32'({bus.memtoreg_out, bus.we_out, bus.reg_en_out}), 32'(ctrl));
        check({tag, "/branch"}, 32'(bus.branch_taken_out), 32'(pcsrc && (a == b2)));
    endtask

    initial begin
        logic seen;
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 1'b0);
        bus.in_valid  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b0;
        #1;
        check("reset/in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back ADD then SLT with out_ready held high.
        drive(0, 32'd5, 32'hFFFF_FFFD, 32'd0, 1'b0, 5'd1, 3'b001, 1'b0);
        @(posedge clock);
        #1;
        check("b2b/add", bus.result_out, 32'd2);
        check("b2b/in_ready", 32'(bus.in_ready), 32'd1);
        drive(5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd2, 3'b001, 1'b0);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("b2b/slt", bus.result_out, 32'd1);
        check("b2b/valid", 32'(bus.out_valid), 32'd1);
        check("b2b/rd", 32'(bus.rd_out), 32'd2);

        run_op("sra4", 9, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd3, 3'b110, 1'b0);
        check("sra4/value", bus.result_out, 32'hF800_0000);

        // Output stall: bundle must hold and in_ready must stay low.
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        drive(0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd7, 3'b101, 1'b0);
        @(posedge clock);
        #1;
        drive(1, 32'd50, 32'd8, 32'd0, 1'b0, 5'd9, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall/valid", 32'(bus.out_valid), 32'd1);
            check("stall/result", bus.result_out, 32'd123);
            check("stall/rd", 32'(bus.rd_out), 32'd7);
            check("stall/ctrl", 32'({bus.memtoreg_out, bus.we_out, bus.reg_en_out}), 32'd5);
            check("stall/in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall/release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("stall/next_result", bus.result_out, 32'd42);
        check("stall/next_rd", 32'(bus.rd_out), 32'd9);

        // Flush during a 20-bit shift.
        drive(7, 32'd1, 32'd0, 32'd20, 1'b1, 5'd4, 3'b111, 1'b0);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        check("flush/busy_before", 32'(bus.busy), 32'd1);
        flush = 1'b1;
        drive(0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd5, 3'b000, 1'b0);
        #1;
        check("flush/in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush/busy_after", 32'(bus.busy), 32'd0);
        check("flush/valid_after", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush/no_result", 32'(seen), 32'd0);

        run_op("mul", 10, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 5'd6, 3'b011, 1'b0);

        // Reset in the middle of a long operation.
        @(posedge clock);
        #1;
`ifdef EX_MUL_EN
        drive(10, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, 5'd17, 3'b111, 1'b1);
`else
        drive(7, 32'h1234_5678, 32'h1234_5678, 32'd31, 1'b1, 5'd17, 3'b111, 1'b1);
`endif
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("midreset/rd_before", 32'(bus.rd_out), 32'd17);
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("midreset/in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 80; i++) begin
            int          op;
            logic [31:0] a, b2, imm;
            logic [4:0]  rd;
            logic [2:0]  ctrl;
            logic        alusrc, pcsrc;
            op     = int'($urandom_range(0, 15));
            a      = $urandom;
            b2     = $urandom;
            imm    = $urandom;
            rd     = 5'($urandom);
            ctrl   = 3'($urandom);
            alusrc = 1'($urandom);
            pcsrc  = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b2 = a;
                1: a = a | 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) imm = imm & 32'hFFFF_FFE0;
            run_op("random", op, a, b2, imm, alusrc, rd, ctrl, pcsrc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
